// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder: mode encoding, one-hot
// expansion and prescaler count width.
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  // Widest select the one-hot helper supports; callers truncate the result.
  localparam int MAX_SEL_W = 8;

  function automatic int count_w(input int div);
    return $clog2(div);
  endfunction

  function automatic logic [2**MAX_SEL_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    return {{(2**MAX_SEL_W-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Bundle between the display controller (master) and the scan decoder (slave).
interface scan_decoder_if #(
  parameter int SEL_W = 3
);
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      a;
  logic [SEL_W-1:0]      scan_last;
  logic [2**SEL_W-1:0]   bcode;
  logic [SEL_W-1:0]      idx;
  logic                  tick;

  modport master (
    output en, mode, a, scan_last,
    input  bcode, idx, tick
  );

  modport slave (
    input  en, mode, a, scan_last,
    output bcode, idx, tick
  );
endinterface

// File: rtl/scan_decoder_prescaler.sv
// Scan-step prescaler: counts DIV cycles per step while run is high and
// emits a registered one-cycle tick on each wrap.
module scan_prescaler
  import scan_decoder_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      clr,
  output logic [count_w(DIV)-1:0]   count_nxt,
  output logic                      wrap,
  output logic                      tick
);
  localparam int CNT_W = count_w(DIV);

  logic [CNT_W-1:0] count_q;
  logic             at_top;

  assign at_top = (count_q == CNT_W'(DIV - 1));
  assign wrap   = run && at_top;

  always_comb begin
    count_nxt = count_q;
    if (clr) begin
      count_nxt = '0;
    end else if (run) begin
      count_nxt = at_top ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick    <= 1'b0;
    end else begin
      count_q <= count_nxt;
      tick    <= wrap;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct and auto-scan modes.
// Define SCAN_BLANK_EN to blank bcode for BLANK_CNT cycles at each scan step.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int DIV       = 50000,
  parameter int BLANK_CNT = 1
) (
  input  logic           clk,
  input  logic           reset,
  scan_decoder_if.slave  bus
);
  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = count_w(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("scan_decoder: DIV must be >= 2");
  end
  if (BLANK_CNT >= DIV) begin : g_bad_blank
    $error("scan_decoder: BLANK_CNT must be < DIV");
  end
  if (SEL_W > MAX_SEL_W) begin : g_bad_sel
    $error("scan_decoder: SEL_W exceeds MAX_SEL_W");
  end

  mode_t            mode_q;
  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_nxt;
  logic [SEL_W-1:0] scan_sel;
  logic [OUT_W-1:0] bcode_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             scan_req;
  logic             entry;
  logic             run;
  logic             wrap;
  logic             tick;
  logic             blank;

  assign scan_req = bus.en && (mode_t'(bus.mode) == MODE_SCAN);
  assign entry    = scan_req && (mode_q == MODE_DIRECT);
  assign run      = scan_req && (mode_q == MODE_SCAN);

  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .clr       (entry),
    .count_nxt (cnt_nxt),
    .wrap      (wrap),
    .tick      (tick)
  );

  // An index left above a lowered scan_last simply holds until the next wrap.
  assign idx_nxt  = wrap ? ((idx_q >= bus.scan_last) ? '0 : idx_q + 1'b1) : idx_q;
  assign scan_sel = entry ? '0 : idx_nxt;

`ifdef SCAN_BLANK_EN
  assign blank = (cnt_nxt < CNT_W'(BLANK_CNT));
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_nxt;
  assign blank      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_DIRECT;
      idx_q   <= '0;
      bcode_q <= '0;
    end else if (!bus.en) begin
      bcode_q <= '0;
    end else begin
      mode_q <= mode_t'(bus.mode);
      if (mode_t'(bus.mode) == MODE_DIRECT) begin
        bcode_q <= OUT_W'(onehot(MAX_SEL_W'(bus.a)));
      end else begin
        idx_q   <= scan_sel;
        bcode_q <= blank ? '0 : OUT_W'(onehot(MAX_SEL_W'(scan_sel)));
      end
    end
  end

  assign bus.bcode = bcode_q;
  assign bus.idx   = idx_q;
  assign bus.tick  = tick;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: a spec-level model queues the expected
// outputs for every cycle and a monitor compares them after each edge.
module tb_scan_decoder;
  localparam int SEL_W     = 3;
  localparam int DIV       = 4;
  localparam int BLANK_CNT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(SEL_W)) bus ();

  scan_decoder #(
    .SEL_W     (SEL_W),
    .DIV       (DIV),
    .BLANK_CNT (BLANK_CNT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] bcode;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   ncyc = 0;

  // Reference state, kept as plain integers
  int   m_cnt   = 0;
  int   m_idx   = 0;
  bit   m_scan  = 0;   // "was in scan mode at last enabled cycle"
  int   m_bcode = 0;
  bit   m_tick  = 0;

  function automatic bit blanked(int cnt);
`ifdef SCAN_BLANK_EN
    return cnt < BLANK_CNT;
`else
    return (cnt < 0);
`endif
  endfunction

  function automatic void model_step(bit r, bit en, bit mode, int a, int last);
    m_tick = 0;
    if (r) begin
      m_cnt = 0; m_idx = 0; m_scan = 0; m_bcode = 0;
    end else if (!en) begin
      m_bcode = 0;
    end else if (!mode) begin
      m_scan  = 0;
      m_bcode = 1 << a;
    end else if (!m_scan) begin
      m_scan  = 1;
      m_cnt   = 0;
      m_idx   = 0;
      m_bcode = blanked(0) ? 0 : 1;
    end else begin
      if (m_cnt == DIV - 1) begin
        m_cnt  = 0;
        m_tick = 1;
        m_idx  = (m_idx >= last) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_bcode = blanked(m_cnt) ? 0 : (1 << m_idx);
    end
  endfunction

  task automatic drive(bit r, bit en, bit mode, int a, int last);
    exp_t e;
    reset         = r;
    bus.en        = en;
    bus.mode      = mode;
    bus.a         = 3'(a);
    bus.scan_last = 3'(last);
    model_step(r, en, mode, a, last);
    e.bcode = 8'(m_bcode);
    e.idx   = 3'(m_idx);
    e.tick  = m_tick;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ncyc++;
        nchk++;
        if (bus.bcode !== e.bcode) begin
          nerr++;
          $display("FAIL bcode cyc=%0d got=%h exp=%h", ncyc, bus.bcode, e.bcode);
        end
        nchk++;
        if (bus.idx !== e.idx) begin
          nerr++;
          $display("FAIL idx cyc=%0d got=%0d exp=%0d", ncyc, bus.idx, e.idx);
        end
        nchk++;
        if (bus.tick !== e.tick) begin
          nerr++;
          $display("FAIL tick cyc=%0d got=%0d exp=%0d", ncyc, bus.tick, e.tick);
        end
      end
    end
  end

  initial begin
    int last;
    bit en_r, mode_r;
    reset = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.scan_last = '0;

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);

    // Direct decode sweep
    for (int i = 0; i < 8; i++) drive(0, 1, 0, i, 7);
    // Disabled sweep, then re-enable
    for (int i = 0; i < 8; i++) drive(0, 0, 0, i, 7);
    drive(0, 1, 0, 5, 7);

    // Full scan over 0..7 and wrap
    for (int i = 0; i < 40; i++) drive(0, 1, 1, 0, 7);

    // Short scan, then lower scan_last to 0 while idx==2
    drive(0, 1, 0, 3, 2);
    for (int i = 0; i < 30; i++) drive(0, 1, 1, 0, 2);
    for (int i = 0; i < 20 && m_idx != 2; i++) drive(0, 1, 1, 0, 2);
    for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0);

    // Pause mid-scan at idx 3, resume, then reset mid-scan
    drive(0, 1, 0, 0, 7);
    for (int i = 0; i < 40 && !(m_idx == 3 && m_cnt == 1); i++) drive(0, 1, 1, 0, 7);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 7);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 7);
    drive(1, 1, 1, 0, 7);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 7);

    // Mode entry while disabled: en dominates, entry deferred
    drive(0, 1, 0, 6, 7);
    drive(0, 0, 1, 6, 7);
    drive(0, 0, 1, 6, 7);
    for (int i = 0; i < 6; i++) drive(0, 1, 1, 6, 7);

    // Randomized traffic
    last   = 7;
    mode_r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) mode_r = ~mode_r;
      if ($urandom_range(29) == 0) last = int'($urandom_range(7));
      en_r = ($urandom_range(9) != 0);
      drive(($urandom_range(99) == 0), en_r, mode_r, int'($urandom_range(7)), last);
    end

    drive(0, 1, 0, 0, 7);
    #20;
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised registered N-to-2^N one-hot decoder with an enable, and the successor to the team's combinational 3-to-8 decoder. It has two modes:
- Direct mode: registered decode of an external select.
- Scan mode: an internal prescaler and index counter rotate the active output, for time-multiplexed digit/LED driving on the prototyping board.

Sits between the display controller and the anode/row drivers.

Parameters:
SEL_W, 3, select/index width; output width is 2**SEL_W.
DIV, 50000, prescaler period in clk cycles per scan step; must be >= 2.
BLANK_CNT, 1, blanking cycles at the start of each step; used only with SCAN_BLANK_EN; must be < DIV.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  enable; 0 forces bcode to all zeros
mode  in  1  0 = direct decode, 1 = auto-scan
a  in  SEL_W  select input (direct mode)
scan_last  in  SEL_W  highest index visited in scan mode (scan length = scan_last+1)
bcode  out  2**SEL_W  registered one-hot output
idx  out  SEL_W  current scan index (registered)
tick  out  1  one-cycle pulse when the scan index advances

Behaviour:
- Reset (sync, active-high, checked at the clk edge): bcode=0, idx=0, tick=0, prescaler count=0, mode_q=0. Reset wins over all other inputs in the same cycle. Reset mid-scan restarts from idx 0 and count 0 on the next edge.
- Output register: bcode is always a flop output; there is no combinational path from inputs to bcode.
- en=0:
  - bcode<=0 on the next edge.
  - Prescaler, idx and tick are frozen; tick=0.
  - When en returns to 1, scan resumes from the held count/idx.
- Direct mode (mode=1'b0, en=1): bcode<=1<<a. Latency is 1 clk. Prescaler and idx hold at their last values.
- Scan-mode entry: mode_q registers mode. On the cycle where mode=1 and mode_q=0, count<=0, idx<=0 and bcode<=1<<0.
- Scan mode (mode=1, en=1, not the entry cycle):
  - count increments each cycle.
  - When count==DIV-1: count<=0, tick<=1, and idx<=(idx>=scan_last) ? 0 : idx+1.
  - bcode<=1<<next_idx on that same edge, so bcode and idx change together.
- Out-of-range index: if scan_last is lowered below the current idx, idx holds until the next tick, then goes to 0. scan_last=0 keeps idx at 0, bcode=1, and tick still pulses every DIV cycles.
- tick is high for exactly one cycle per step, coincident with the new idx/bcode.
- Widths: count is $clog2(DIV) bits. The idx+1 comparison is done at SEL_W bits; idx never exceeds 2**SEL_W-1.
- Simultaneous mode 0->1 and en 1->0: en dominates (outputs zero, state frozen). The entry still occurs on the first cycle with en=1 and mode=1, because mode_q updates only when en=1.

Optional Feature:
SCAN_BLANK_EN
- Defined: in scan mode bcode is forced to 0 while count < BLANK_CNT, giving a dead time after each step to remove display ghosting. idx and tick are unaffected. Direct mode is unaffected.
- Undefined: no blanking. BLANK_CNT is ignored, and the logic and comparator are absent.

Decomposition:
- Package scan_decoder_pkg:
  - typedef mode_t enum {MODE_DIRECT=1'b0, MODE_SCAN=1'b1}.
  - Function onehot(sel) returning 1<<sel.
  - Localparam helper for the count width.
- One sub-module, scan_prescaler: count register and tick generation, with clk, reset, run and tick ports. The top holds idx, mode_q and the bcode register.

Test Plan:
(SEL_W=3, DIV=4, BLANK_CNT=1.)
- Reset, then en=1, mode=0, sweep a=0..7 one per cycle -> bcode one cycle later = 8'h01, 02, 04 … 80; idx=0; tick never asserted.
- en=0, mode=0, sweep a=0..7 -> bcode=8'h00 throughout; en back to 1 with a=5 -> bcode=8'h20 after 1 clk.
- mode 0->1, scan_last=7 -> bcode=8'h01 on the entry edge; idx steps 0,1…7,0 every 4 clks; tick pulses every 4th cycle aligned with the idx change.
- Scan with scan_last=2 -> idx sequence 0,1,2,0,1,2. Lower scan_last to 0 while idx=2 -> next tick gives idx=0 and it stays 0, bcode=8'h01.
- Mid-scan at idx=3: deassert en for 10 clks -> bcode=0, idx=3 held, no tick. Reassert en -> the remaining count completes, then idx=4. Assert reset mid-scan -> bcode=0, idx=0, tick=0 next edge.
- With SCAN_BLANK_EN defined: scan mode -> bcode=0 on the first cycle of each step and one-hot for the remaining 3 cycles. Without the macro -> bcode is never 0 during scan.
